// File: rtl/port_arbiter4.sv
// port_arbiter4: round-robin arbiter granting one of four requesters a shared port,
// with completion/timeout handling and one-cycle release between transactions.
module port_arbiter4 #(
  parameter int MAX_WAIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       mem_ready,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       mem_valid,
  output logic [3:0] done,
  output logic       err
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY    = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;
  localparam logic [7:0] LIMIT   = 8'(MAX_WAIT - 1);
  logic [1:0] state;
  logic [1:0] last;
  logic [1:0] win;
  logic [1:0] idx;
  logic [7:0] cnt;
  // lowest offset from last+1 wins, so scan downward and let later hits overwrite
  always_comb begin
    win = last + 2'd1;
    idx = '0;
    for (int i = 3; i >= 0; i--) begin
      idx = last + 2'(i + 1);
      if (req[idx]) win = idx;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sel       <= '0;
      gnt       <= '0;
      mem_valid <= 1'b0;
      done      <= '0;
      err       <= 1'b0;
      cnt       <= '0;
      last      <= 2'd3;
    end else begin
      done <= '0;
      err  <= 1'b0;
      if (state == IDLE) begin
        if (|req) begin
          state     <= BUSY;
          sel       <= win;
          gnt       <= 4'(1) << win;
          mem_valid <= 1'b1;
          cnt       <= '0;
        end
      end else if (state == BUSY) begin
        if (mem_ready || cnt == LIMIT) begin
          state     <= RELEASE;
          done      <= mem_ready ? gnt : 4'd0;
          err       <= !mem_ready;
          mem_valid <= 1'b0;
          gnt       <= '0;
          last      <= sel;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: doc/port_arbiter4.md
PORT_ARBITER4 -- requirements
Module: port_arbiter4

Interface
REQ-001 Parameter MAX_WAIT, default 16: maximum BUSY cycles allowed per transaction; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-004 req  input  4  per-requester request level; bit i = requester i wants the shared port.
REQ-005 mem_ready  input  1  shared-resource completion pulse; valid only in BUSY.
REQ-006 sel  output  2  select code for the downstream 4:1 N-bit muxes (addr/wdata/ctrl); equals the granted index.
REQ-007 gnt  output  4  one-hot grant; all-zero when no grant.
REQ-008 mem_valid  output  1  asserts a request to the shared resource.
REQ-009 done  output  4  one-hot, one-cycle pulse: granted transaction completed.
REQ-010 err  output  1  one-cycle pulse: granted transaction aborted by timeout.

Function
REQ-011 The FSM SHALL have three states: IDLE, BUSY, RELEASE; all outputs are registered.
REQ-012 IDLE: if req != 0, the winner SHALL be the first set bit scanning from (last+1) mod 4 upward, wrapping; go to BUSY; else stay IDLE.
REQ-013 On IDLE->BUSY, at the same edge: sel = winner, gnt = 1<<winner, mem_valid = 1, wait counter = 0.
REQ-014 Grant latency SHALL be exactly 1 cycle: req sampled in IDLE at edge t gives gnt/sel/mem_valid visible after edge t.
REQ-015 BUSY: sel and gnt SHALL stay constant; changes on req (including deassertion by the granted requester) SHALL be ignored until RELEASE.
REQ-016 BUSY with mem_ready = 1: go to RELEASE; set done = gnt, mem_valid = 0, gnt = 0, last = sel.
REQ-017 BUSY without mem_ready: the 8-bit counter SHALL increment; when counter == MAX_WAIT-1, go to RELEASE with err = 1, done = 0, mem_valid = 0, gnt = 0, last = sel.
REQ-018 mem_ready and timeout in the same cycle: completion SHALL win (done pulse, no err).
REQ-019 RELEASE SHALL last exactly one cycle: done/err visible, req ignored, then IDLE with done = 0 and err = 0.
REQ-020 sel SHALL hold its last value through RELEASE and IDLE; only a new grant changes it.
REQ-021 mem_ready in IDLE or RELEASE SHALL be ignored.
REQ-022 done and err SHALL never be asserted together; gnt SHALL never have more than one bit set.
REQ-023 Back-to-back throughput: completion at edge k gives a new grant after edge k+2 at the earliest.

Reset
REQ-024 rst = 0 SHALL immediately force IDLE, sel = 0, gnt = 0, mem_valid = 0, done = 0, err = 0, counter = 0, last = 3, independent of clk.
REQ-025 Reset during BUSY SHALL abort the transaction with no done and no err pulse; the first arbitration after release favours requester 0.
REQ-026 Deassertion of rst SHALL be synchronised by the system; the block takes its first IDLE decision at the first clk edge with rst = 1.

Verification
REQ-027 Reset, req=0001 held, mem_ready 2 cycles after grant -> gnt=0001, sel=00, mem_valid=1 one cycle after req; done=0001 for one cycle after mem_ready; err=0.
REQ-028 req=1111 held, mem_ready on the first BUSY cycle each time -> grant order 0,1,2,3,0; gnt one-hot throughout; 3 cycles between successive grants.
REQ-029 MAX_WAIT=4, req=0100, mem_ready never -> 4 BUSY cycles, then err=1 for one cycle, done=0000; with req=1100 held, next grant is 1000.
REQ-030 MAX_WAIT=4, mem_ready asserted on the 4th BUSY cycle -> done=gnt pulse, err stays 0.
REQ-031 rst=0 mid-BUSY between clk edges -> gnt, mem_valid, sel, done, err all 0 immediately; after release, req=1001 -> grant to requester 0.
REQ-032 req=0010 granted, req dropped to 0 in BUSY, mem_ready later -> transaction still completes with done=0010; mem_ready pulses in IDLE produce no output change.
